// File: rtl/controle_placar.sv
// Scoreboard score sequencer: synchronises and debounces the point buttons, then
// applies one range-checked +/-1..3 update per press to the selected team's score.
module controle_placar #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CW              = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] botoes,
  input  logic       chave_time,
  input  logic       chave_sub,
  input  logic       zerar,
  output logic [6:0] placar_t1,
  output logic [6:0] placar_t2,
  output logic       erro,
  output logic       atualizou
);

  typedef enum logic [1:0] {OCIOSO, FILTRO, APLICA, ESPERA_SOLTAR} estado_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  estado_t       est_q,  est_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [2:0]    bs1_q,  bs_q;
  logic [2:0]    pat_q,  pat_d;
  logic [1:0]    pts_q,  pts_d;
  logic          time_q, time_d;
  logic          sub_q,  sub_d;
  logic [6:0]    t1_q,   t1_d;
  logic [6:0]    t2_q,   t2_d;
  logic          erro_q, erro_d;

  logic          um_bit;
  logic [6:0]    s;
  logic [7:0]    soma;
  logic [6:0]    novo;
  logic          ok;

  // Exactly one button pressed; chords are ignored.
  assign um_bit = (bs_q == 3'b001) || (bs_q == 3'b010) || (bs_q == 3'b100);

  assign s    = time_q ? t2_q : t1_q;
  assign soma = {1'b0, s} + {6'd0, pts_q};
  assign ok   = sub_q ? (s >= {5'd0, pts_q}) : (soma <= 8'd99);
  assign novo = sub_q ? (s - {5'd0, pts_q}) : soma[6:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bs1_q  <= '0;
      bs_q   <= '0;
      est_q  <= OCIOSO;
      cnt_q  <= '0;
      pat_q  <= '0;
      pts_q  <= '0;
      time_q <= 1'b0;
      sub_q  <= 1'b0;
      t1_q   <= '0;
      t2_q   <= '0;
      erro_q <= 1'b0;
    end else begin
      bs1_q  <= botoes;
      bs_q   <= bs1_q;
      est_q  <= est_d;
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      pts_q  <= pts_d;
      time_q <= time_d;
      sub_q  <= sub_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      erro_q <= erro_d;
    end
  end

  always_comb begin
    est_d     = est_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    pts_d     = pts_q;
    time_d    = time_q;
    sub_d     = sub_q;
    t1_d      = t1_q;
    t2_d      = t2_q;
    erro_d    = erro_q;
    atualizou = 1'b0;

    case (est_q)
      OCIOSO: begin
        if (um_bit) begin
          pat_d  = bs_q;
          pts_d  = bs_q[0] ? 2'd1 : (bs_q[1] ? 2'd2 : 2'd3);
          time_d = chave_time;
          sub_d  = chave_sub;
          cnt_d  = '0;
          est_d  = FILTRO;
        end
      end
      FILTRO: begin
        if (bs_q != pat_q) begin
          cnt_d = '0;
          est_d = OCIOSO;
        end else if (cnt_q == CNT_MAX) begin
          est_d = APLICA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      APLICA: begin
        cnt_d = '0;
        est_d = ESPERA_SOLTAR;
        // A simultaneous clear wins and the pending event is dropped.
        if (!zerar) begin
          if (ok) begin
            if (time_q) t2_d = novo;
            else        t1_d = novo;
            erro_d    = 1'b0;
            atualizou = 1'b1;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      ESPERA_SOLTAR: begin
        if (bs_q != 3'b000) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          est_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        est_d = OCIOSO;
      end
    endcase

    if (zerar) begin
      t1_d   = '0;
      t2_d   = '0;
      erro_d = 1'b0;
    end
  end

  assign placar_t1 = t1_q;
  assign placar_t2 = t2_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_controle_placar.sv
// Scoreboard bench for controle_placar: a behavioural score model queues the
// expected outcome of each button event, checked once the event has settled.
module tb_controle_placar;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] botoes = 3'b000;
  logic       chave_time = 1'b0;
  logic       chave_sub = 1'b0;
  logic       zerar = 1'b0;
  logic [6:0] placar_t1, placar_t2;
  logic       erro, atualizou;

  controle_placar #(.DEBOUNCE_CYCLES(DB), .CW(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .botoes    (botoes),
    .chave_time(chave_time),
    .chave_sub (chave_sub),
    .zerar     (zerar),
    .placar_t1 (placar_t1),
    .placar_t2 (placar_t2),
    .erro      (erro),
    .atualizou (atualizou)
  );

  always #5 clock = ~clock;

  typedef struct {
    int t1;
    int t2;
    int er;
    int pulses;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_t1 = 0, m_t2 = 0, m_er = 0;
  int   pulse_cnt = 0;

  // Count cycles with atualizou high, sampled mid-low-phase after inputs settle.
  always begin
    @(negedge clock);
    #2;
    if (atualizou === 1'b1) pulse_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model one button event and queue its expected outcome.
  task automatic model(input logic [2:0] b, input bit team, input bit sub);
    exp_t e;
    int pts, s;
    pts = (b == 3'b001) ? 1 : (b == 3'b010) ? 2 : (b == 3'b100) ? 3 : 0;
    s = team ? m_t2 : m_t1;
    e.pulses = 0;
    if (pts != 0) begin
      if (!sub && (s + pts <= 99)) begin
        s += pts; m_er = 0; e.pulses = 1;
      end else if (sub && (s >= pts)) begin
        s -= pts; m_er = 0; e.pulses = 1;
      end else begin
        m_er = 1;
      end
      if (team) m_t2 = s; else m_t1 = s;
    end
    e.t1 = m_t1; e.t2 = m_t2; e.er = m_er;
    sb.push_back(e);
  endtask

  task automatic push_zero(input int pulses);
    exp_t e;
    m_t1 = 0; m_t2 = 0; m_er = 0;
    e.t1 = 0; e.t2 = 0; e.er = 0; e.pulses = pulses;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag, input int p0);
    exp_t e;
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_t1"}, int'(placar_t1), e.t1);
      chk({tag, "_t2"}, int'(placar_t2), e.t2);
      chk({tag, "_erro"}, int'(erro), e.er);
      chk({tag, "_pulses"}, pulse_cnt - p0, e.pulses);
    end
  endtask

  task automatic press(input string tag, input logic [2:0] b, input bit team,
                       input bit sub, input bit bounce, input bit flip);
    int p0;
    model(b, team, sub);
    p0 = pulse_cnt;
    @(negedge clock);
    chave_time = team;
    chave_sub  = sub;
    if (bounce) begin
      botoes = b;
      repeat (2) @(negedge clock);
      botoes = 3'b000;
      @(negedge clock);
    end
    botoes = b;
    if (flip) begin
      repeat (4) @(negedge clock);
      chave_time = ~team;
      chave_sub  = ~sub;
    end
    repeat (20) @(negedge clock);
    botoes = 3'b000;
    repeat (DB + 6) @(negedge clock);
    chave_time = 1'b0;
    chave_sub  = 1'b0;
    compare(tag, p0);
  endtask

  task automatic clear(input string tag);
    int p0;
    push_zero(0);
    p0 = pulse_cnt;
    @(negedge clock);
    zerar = 1'b1;
    @(negedge clock);
    zerar = 1'b0;
    repeat (2) @(negedge clock);
    compare(tag, p0);
  endtask

  initial begin
    int p0;

    // Reset state
    #1;
    chk("rst_t1", int'(placar_t1), 0);
    chk("rst_t2", int'(placar_t2), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_atu", int'(atualizou), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 1: held 3pt on team 1, exact timing of update and pulse
    model(3'b100, 1'b0, 1'b0);
    p0 = pulse_cnt;
    botoes = 3'b100;
    repeat (7) @(negedge clock);
    chk("t1_apl_atu", int'(atualizou), 1);
    chk("t1_apl_t1", int'(placar_t1), 0);
    @(negedge clock);
    chk("t1_e7_t1", int'(placar_t1), 3);
    chk("t1_e7_atu", int'(atualizou), 0);
    repeat (12) @(negedge clock);
    botoes = 3'b000;
    repeat (DB + 6) @(negedge clock);
    compare("hold", p0);

    // 2: bounce before a stable press
    clear("clr2");
    press("bounce", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);

    // 3: saturation at 99 on team 2
    clear("clr3");
    for (int i = 0; i < 49; i++) press("fill", 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    press("sat", 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    press("top", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4: underflow on team 1
    clear("clr4");
    press("one", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    press("under", 3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
    press("zero", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: chord ignored, late switch changes ignored
    press("chord", 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
    press("late", 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    press("late2", 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);

    // 6a: clear during the APLICA cycle
    push_zero(0);
    p0 = pulse_cnt;
    @(negedge clock);
    chave_time = 1'b0;
    botoes = 3'b001;
    repeat (7) @(negedge clock);
    zerar = 1'b1;
    #1;
    chk("zapl_atu", int'(atualizou), 0);
    @(negedge clock);
    zerar = 1'b0;
    repeat (12) @(negedge clock);
    botoes = 3'b000;
    repeat (DB + 6) @(negedge clock);
    compare("zapl", p0);

    // 6b: async reset mid-FILTRO
    press("pre_rst", 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    push_zero(0);
    p0 = pulse_cnt;
    @(negedge clock);
    botoes = 3'b001;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    botoes = 3'b000;
    #1;
    chk("arst_t1", int'(placar_t1), 0);
    chk("arst_t2", int'(placar_t2), 0);
    chk("arst_erro", int'(erro), 0);
    chk("arst_atu", int'(atualizou), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (DB + 10) @(negedge clock);
    compare("arst", p0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
